// File: rtl/ab_stream_pkg.sv
// Shared types for the a/b operand stream transmitter: controller states,
// channel identifiers and the FIFO room check used by the read arbiter.
package ab_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        CH_A,
        CH_B
    } chan_t;

    localparam int FIFO_DEPTH = 2;

    // True when a new read can be issued without overflowing a 2-entry FIFO.
    // The word leaving the FIFO this cycle frees its slot, which is what lets
    // a single channel sustain one word per cycle.
    function automatic logic fifo_has_room(
        input logic [1:0] level,
        input logic       full,
        input logic       pop,
        input logic       inflight
    );
        logic [1:0] after_pop;
        if (full) begin
            return pop && !inflight;
        end
        after_pop = level - {1'b0, pop};
        return (after_pop + {1'b0, inflight}) < 2'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO with registered storage; simultaneous push and pop on a
// full FIFO is accepted and leaves the level unchanged.
module stream_fifo2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [1:0]       level
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == 2'd2);
    assign empty = (level == 2'd0);

endmodule

// File: rtl/ab_stream_tx.sv
// Streams A (activation) and B (kernel) words fetched from a staging memory
// onto two valid/ready channels, sharing one 1-cycle-latency read port.
module ab_stream_tx
    import ab_stream_pkg::*;
#(
    parameter int IO_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int LEN_WIDTH     = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     arst_in,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    a_base,
    input  logic [LEN_WIDTH-1:0]     a_len,
    input  logic [ADDR_WIDTH-1:0]    b_base,
    input  logic [LEN_WIDTH-1:0]     b_len,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_WIDTH-1:0]    src_read_addr,
    output logic                     src_read_en,
    input  logic [IO_DATA_WIDTH-1:0] src_qout,
    output logic [IO_DATA_WIDTH-1:0] a_output,
    output logic                     a_valid,
    input  logic                     a_ready,
    output logic [IO_DATA_WIDTH-1:0] b_output,
    output logic                     b_valid,
    input  logic                     b_ready,
    output logic [CNT_WIDTH-1:0]     a_count,
    output logic [CNT_WIDTH-1:0]     b_count
);

    state_t                state;
    state_t                state_next;

    logic [ADDR_WIDTH-1:0] a_base_r;
    logic [ADDR_WIDTH-1:0] b_base_r;
    logic [LEN_WIDTH-1:0]  a_len_r;
    logic [LEN_WIDTH-1:0]  b_len_r;
    logic [LEN_WIDTH-1:0]  a_issued;
    logic [LEN_WIDTH-1:0]  b_issued;

    logic                  rd_valid;
    chan_t                 rd_tag;
    chan_t                 last_grant;

    logic                  a_push;
    logic                  b_push;
    logic                  a_pop;
    logic                  b_pop;
    logic                  a_full;
    logic                  b_full;
    logic                  a_empty;
    logic                  b_empty;
    logic [1:0]            a_level;
    logic [1:0]            b_level;
    logic                  a_inflight;
    logic                  b_inflight;
    logic                  a_eligible;
    logic                  b_eligible;
    logic                  a_complete;
    logic                  b_complete;
    logic                  grant_a;
    logic                  grant_b;
    logic                  start_accept;

    stream_fifo2 #(
        .WIDTH(IO_DATA_WIDTH)
    ) u_fifo_a (
        .clk      (clk),
        .arst_in  (arst_in),
        .push     (a_push),
        .push_data(src_qout),
        .pop      (a_pop),
        .head     (a_output),
        .full     (a_full),
        .empty    (a_empty),
        .level    (a_level)
    );

    stream_fifo2 #(
        .WIDTH(IO_DATA_WIDTH)
    ) u_fifo_b (
        .clk      (clk),
        .arst_in  (arst_in),
        .push     (b_push),
        .push_data(src_qout),
        .pop      (b_pop),
        .head     (b_output),
        .full     (b_full),
        .empty    (b_empty),
        .level    (b_level)
    );

    assign a_valid = !a_empty;
    assign b_valid = !b_empty;
    assign a_pop   = a_valid && a_ready;
    assign b_pop   = b_valid && b_ready;

    // The tag registered alongside each read steers the returning word.
    assign a_inflight = rd_valid && (rd_tag == CH_A);
    assign b_inflight = rd_valid && (rd_tag == CH_B);
    assign a_push     = a_inflight;
    assign b_push     = b_inflight;

    assign a_eligible = (state == RUN) && (a_issued < a_len_r)
                        && fifo_has_room(a_level, a_full, a_pop, a_inflight);
    assign b_eligible = (state == RUN) && (b_issued < b_len_r)
                        && fifo_has_room(b_level, b_full, b_pop, b_inflight);

    assign a_complete = (a_issued == a_len_r) && a_empty && !a_inflight;
    assign b_complete = (b_issued == b_len_r) && b_empty && !b_inflight;

    assign start_accept = (state == IDLE) && start;

    // Single read port: on contention the channel not granted last time wins.
    always_comb begin
        grant_a       = 1'b0;
        grant_b       = 1'b0;
        src_read_en   = 1'b0;
        src_read_addr = '0;
        if (a_eligible && (!b_eligible || last_grant == CH_B)) begin
            grant_a = 1'b1;
        end else if (b_eligible) begin
            grant_b = 1'b1;
        end
        if (grant_a) begin
            src_read_en   = 1'b1;
            src_read_addr = a_base_r + ADDR_WIDTH'(a_issued);
        end else if (grant_b) begin
            src_read_en   = 1'b1;
            src_read_addr = b_base_r + ADDR_WIDTH'(b_issued);
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // With both lengths zero there is nothing to move, so skip RUN entirely.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ((a_len == '0) && (b_len == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (a_complete && b_complete) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            a_base_r   <= '0;
            b_base_r   <= '0;
            a_len_r    <= '0;
            b_len_r    <= '0;
            a_issued   <= '0;
            b_issued   <= '0;
            a_count    <= '0;
            b_count    <= '0;
            rd_valid   <= 1'b0;
            rd_tag     <= CH_A;
            last_grant <= CH_B;
        end else begin
            if (start_accept) begin
                a_base_r <= a_base;
                b_base_r <= b_base;
                a_len_r  <= a_len;
                b_len_r  <= b_len;
                a_issued <= '0;
                b_issued <= '0;
                a_count  <= '0;
                b_count  <= '0;
            end else begin
                if (grant_a) begin
                    a_issued <= a_issued + LEN_WIDTH'(1);
                end
                if (grant_b) begin
                    b_issued <= b_issued + LEN_WIDTH'(1);
                end
                if (a_pop) begin
                    a_count <= a_count + CNT_WIDTH'(1);
                end
                if (b_pop) begin
                    b_count <= b_count + CNT_WIDTH'(1);
                end
            end
            rd_valid <= src_read_en;
            rd_tag   <= grant_b ? CH_B : CH_A;
            if (src_read_en) begin
                last_grant <= grant_b ? CH_B : CH_A;
            end
        end
    end

endmodule

// File: doc/ab_stream_tx.md
Name: ab_stream_tx

Overview:
- Transmitter end of the chip's a/b operand input handshake (a_input/a_valid/a_ready, b_input/b_valid/b_ready).
- Fetches activation (A) and kernel (B) words from a staging memory through a single read port. The port has 1-cycle read latency and the same read_addr/read_en/qout protocol as the system memory.
- Streams the words on two independent valid/ready channels and counts transferred words for bandwidth accounting.
- Sits in top_system beside top_chip, driving the chip's a/b inputs.

Parameters:
- IO_DATA_WIDTH, 16, width of each streamed word and of src_qout.
- ADDR_WIDTH, 16, staging-memory address width.
- LEN_WIDTH, 16, width of per-channel transfer length.
- CNT_WIDTH, 32, width of bandwidth counters.

Ports:
- clk  in  1  clock, all logic on rising edge.
- arst_in  in  1  asynchronous reset, active-high.
- start  in  1  begin a transfer; sampled only in IDLE.
- a_base  in  ADDR_WIDTH  first A word address; captured at start.
- a_len  in  LEN_WIDTH  number of A words; captured at start.
- b_base  in  ADDR_WIDTH  first B word address; captured at start.
- b_len  in  LEN_WIDTH  number of B words; captured at start.
- busy  out  1  high from the edge that samples start until done.
- done  out  1  one-cycle pulse when all A and B words have handshaked.
- src_read_addr  out  ADDR_WIDTH  staging-memory read address.
- src_read_en  out  1  read request; data appears on src_qout one cycle later.
- src_qout  in  IO_DATA_WIDTH  read data.
- a_output  out  IO_DATA_WIDTH  A data.
- a_valid  out  1  A data valid.
- a_ready  in  1  A consumer ready.
- b_output  out  IO_DATA_WIDTH  B data.
- b_valid  out  1  B data valid.
- b_ready  in  1  B consumer ready.
- a_count  out  CNT_WIDTH  A handshakes since last start.
- b_count  out  CNT_WIDTH  B handshakes since last start.

Behaviour:
- Reset values, asserted asynchronously: every output is 0; state is IDLE; FIFOs are empty; any in-flight read tag is cleared and its returning data is discarded.
- FSM:
  - IDLE: start=1 → RUN. The same edge captures bases and lengths, zeroes the indices and counters, and sets busy.
  - RUN: when both channels have issued and handshaked all words → DONE.
  - DONE: lasts one cycle; done=1 and busy=0 in that cycle; then → IDLE.
- Zero length: a channel with len=0 is complete immediately. With both lengths 0, DONE follows the start edge directly.
- start while not in IDLE is ignored.
- Each channel has a 2-entry FIFO.
  - A channel is eligible to read when its issued count < len and (occupancy + in-flight) < 2.
- Read port:
  - At most one read per cycle.
  - If exactly one channel is eligible, it is granted.
  - If both are eligible, the one not granted most recently wins; after reset A has priority.
  - src_read_en and src_read_addr are combinational from state/grant.
  - Address is base + index, modulo 2^ADDR_WIDTH; wrap-around is legal.
- A 1-bit tag registered with each read routes the next cycle's src_qout into the granted channel's FIFO.
- Latency: start sampled at edge E0 → first read issued in the cycle after E0 → data pushed at E2 → a_valid rises after E2 (A wins the first grant). B's first word follows one cycle later.
- Throughput: combined maximum 1 word/cycle. A single channel with constant ready sustains 1 word/cycle.
- Handshake rules:
  - x_valid = FIFO non-empty.
  - x_output = FIFO head.
  - While x_valid && !x_ready, data and valid stay stable.
  - A word pops on x_valid && x_ready.
  - Push and pop in the same cycle on a full FIFO is legal; occupancy is unchanged.
- Counters increment on each handshake, wrap at 2^CNT_WIDTH, and hold after done until the next start.
- Stalls: a channel stalled indefinitely (ready=0) stops issuing once its FIFO+in-flight reaches 2. The other channel proceeds at full rate.

Decomposition:
- Shared package ab_stream_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - channel-select enum {CH_A, CH_B}.
- One sub-module, stream_fifo2: 2-entry FIFO with push/pop, full/empty and a 2-bit level; instantiated twice.

Test Plan:
- Basic stream: a_base=0x10, a_len=4, b_base=0x80, b_len=3, memory[i]=i, ready tied 1 → A emits 0x10..0x13, B emits 0x80..0x82, in order. a_valid first rises after E2; done pulses once; a_count=4, b_count=3.
- Backpressure: a_ready=0 for 10 cycles mid-stream → a_output stable while valid; at most 2 A reads outstanding; B completes unaffected; no word lost or duplicated.
- Contention fairness: both channels ready, len=8 each → reads alternate A,B,A,B starting with A; done after the 16th handshake.
- Zero/wrap: a_len=0, b_base=0xFFFE, b_len=4 → B reads 0xFFFE, 0xFFFF, 0x0000, 0x0001; a_valid never rises; a_count=0.
- Reset mid-transfer: assert arst_in during RUN with one read in flight → all outputs 0 immediately; the late src_qout is not pushed. A fresh start behaves as the basic-stream case.
- Ignored start: pulse start during RUN with different bases → the transfer continues with the original parameters; exactly one done pulse.
